// File: rtl/pop_count_ctrl_if.sv
// Request/result and shifter-side signals of the Hamming-distance popcount controller.
// The controller uses the slave modport; the requester plus shifter side uses master.
interface pop_count_ctrl_if;
  logic         i_start;
  logic [127:0] i_data_a;
  logic [127:0] i_data_b;
  logic [7:0]   i_threshold;
  logic [6:0]   o_shift_command;
  logic [127:0] o_shift_data;
  logic [127:0] i_shifted_data;
  logic         o_busy;
  logic         o_done;
  logic [7:0]   o_count;
  logic         o_above;

  modport slave (
    input  i_start, i_data_a, i_data_b, i_threshold, i_shifted_data,
    output o_shift_command, o_shift_data, o_busy, o_done, o_count, o_above
  );

  modport master (
    output i_start, i_data_a, i_data_b, i_threshold, i_shifted_data,
    input  o_shift_command, o_shift_data, o_busy, o_done, o_count, o_above
  );
endinterface

// File: rtl/pop_count_ctrl.sv
// Seven-stage SWAR popcount sequencer driving an external one-hot 128-bit shifter;
// reports the Hamming distance (or agreement count) and a threshold compare.
//
// state | meaning
// IDLE  | waiting for i_start, shifter in pass-through
// RUN   | one SWAR fold per clock, stage 0..6
// DONE  | result just loaded, o_done high for this cycle
module pop_count_ctrl #(
  parameter bit XOR_EN        = 1'b1,
  parameter bit COUNT_MATCHES = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  pop_count_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [127:0] M0 = {64{2'b01}};
  localparam logic [127:0] M1 = {32{4'b0011}};
  localparam logic [127:0] M2 = {16{8'h0F}};
  localparam logic [127:0] M3 = {8{16'h00FF}};
  localparam logic [127:0] M4 = {4{32'h0000FFFF}};
  localparam logic [127:0] M5 = {2{64'h00000000FFFFFFFF}};
  localparam logic [127:0] M6 = {64'h0, {64{1'b1}}};

  state_t       state_q, state_d;
  logic [2:0]   stage_q, stage_d;
  logic [127:0] acc_q, acc_d;
  logic [7:0]   thr_q, thr_d;
  logic [7:0]   count_q, count_d;
  logic         above_q, above_d;
  logic         done_q, done_d;

  logic [127:0] mask;
  logic [127:0] sum;
  logic [7:0]   result;

  always_comb begin
    mask = M6;
    case (stage_q)
      3'd0:    mask = M0;
      3'd1:    mask = M1;
      3'd2:    mask = M2;
      3'd3:    mask = M3;
      3'd4:    mask = M4;
      3'd5:    mask = M5;
      default: mask = M6;
    endcase
  end

  // Masked fields leave headroom, so the full-width add never carries between fields.
  assign sum    = (acc_q & mask) + (bus.i_shifted_data & mask);
  assign result = COUNT_MATCHES ? (8'd128 - sum[7:0]) : sum[7:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      stage_q <= 3'd0;
      acc_q   <= '0;
      thr_q   <= 8'd0;
      count_q <= 8'd0;
      above_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      acc_q   <= acc_d;
      thr_q   <= thr_d;
      count_q <= count_d;
      above_q <= above_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    acc_d   = acc_q;
    thr_d   = thr_q;
    count_d = count_q;
    above_d = above_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.i_start) begin
          acc_d   = XOR_EN ? (bus.i_data_a ^ bus.i_data_b) : bus.i_data_a;
          thr_d   = bus.i_threshold;
          stage_d = 3'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = sum;
        stage_d = stage_q + 3'd1;
        if (stage_q == 3'd6) begin
          count_d = result;
          above_d = (result >= thr_q);
          done_d  = 1'b1;
          stage_d = 3'd0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_shift_command = (state_q == RUN) ? (7'b0000001 << stage_q) : 7'b0000000;
  assign bus.o_shift_data    = acc_q;
  assign bus.o_busy          = (state_q == RUN);
  assign bus.o_done          = done_q;
  assign bus.o_count         = count_q;
  assign bus.o_above         = above_q;

endmodule

// File: tb/tb_pop_count_ctrl.sv
// Directed and random checks of pop_count_ctrl in distance and match modes,
// with a behavioural model of the one-hot right shifter.
module tb_pop_count_ctrl;

  logic i_clk;
  logic i_rst_n;

  pop_count_ctrl_if bus ();
  pop_count_ctrl_if bus_m ();

  pop_count_ctrl #(.XOR_EN(1'b1), .COUNT_MATCHES(1'b0)) u_dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  pop_count_ctrl #(.XOR_EN(1'b1), .COUNT_MATCHES(1'b1)) u_dut_m (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus_m.slave)
  );

  function automatic logic [127:0] shifter(input logic [127:0] d, input logic [6:0] c);
    case (c)
      7'h01:   return d >> 1;
      7'h02:   return d >> 2;
      7'h04:   return d >> 4;
      7'h08:   return d >> 8;
      7'h10:   return d >> 16;
      7'h20:   return d >> 32;
      7'h40:   return d >> 64;
      default: return d;
    endcase
  endfunction

  assign bus.i_shifted_data   = shifter(bus.o_shift_data, bus.o_shift_command);
  assign bus_m.i_shifted_data = shifter(bus_m.o_shift_data, bus_m.o_shift_command);

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [7:0]   thr;
    logic [7:0]   cnt;
    logic         above;
    logic [7:0]   cnt_m;
    logic         above_m;
  } vec_t;

  vec_t vecs[11];

  // Drives one request into both DUTs and checks sequencing and results.
  task automatic do_op(input logic [127:0] a, input logic [127:0] b, input logic [7:0] thr,
                       input logic [7:0] ec, input logic ea, input logic [7:0] ecm,
                       input logic eam, input string nm);
    bit got;
    int lat;
    @(negedge i_clk);
    bus.i_data_a = a;   bus.i_data_b = b;   bus.i_threshold = thr;   bus.i_start = 1'b1;
    bus_m.i_data_a = a; bus_m.i_data_b = b; bus_m.i_threshold = thr; bus_m.i_start = 1'b1;
    @(posedge i_clk);
    #1;
    chk({nm, "/cmd0"}, bus.o_shift_command, 7'h01);
    chk({nm, "/busy"}, bus.o_busy, 1'b1);
    @(negedge i_clk);
    bus.i_start = 1'b0;
    bus_m.i_start = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_done) begin
        got = 1'b1;
        lat = i;
      end else if (i < 7) begin
        chk($sformatf("%s/cmd%0d", nm, i), bus.o_shift_command, 7'b0000001 << i);
      end
    end
    chk({nm, "/latency"}, lat, 7);
    chk({nm, "/count"}, bus.o_count, ec);
    chk({nm, "/above"}, bus.o_above, ea);
    chk({nm, "/cmd_done"}, bus.o_shift_command, 7'h00);
    chk({nm, "/busy_done"}, bus.o_busy, 1'b0);
    chk({nm, "/m_done"}, bus_m.o_done, 1'b1);
    chk({nm, "/m_count"}, bus_m.o_count, ecm);
    chk({nm, "/m_above"}, bus_m.o_above, eam);
    @(posedge i_clk);
    #1;
    chk({nm, "/done_pulse"}, bus.o_done, 1'b0);
  endtask

  initial begin
    int nd, d1, d2;
    logic [7:0] c1, c2;
    logic [127:0] x1, x2, ra, rb;
    logic [7:0] rthr, rc, rcm;

    vecs[0]  = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8'd0, 8'd0, 1'b1, 8'd128, 1'b1};
    vecs[1]  = '{{128{1'b1}}, 128'h0, 8'd128, 8'd128, 1'b1, 8'd0, 1'b0};
    vecs[2]  = '{{64{2'b10}}, 128'h0, 8'd64, 8'd64, 1'b1, 8'd64, 1'b1};
    vecs[3]  = '{{64{2'b10}}, 128'h0, 8'd65, 8'd64, 1'b0, 8'd64, 1'b0};
    vecs[4]  = '{{64{2'b10}}, 128'h0, 8'd0, 8'd64, 1'b1, 8'd64, 1'b1};
    vecs[5]  = '{{64{2'b10}}, 128'h0, 8'd200, 8'd64, 1'b0, 8'd64, 1'b0};
    vecs[6]  = '{{1'b1, 127'h0}, 128'h0, 8'd1, 8'd1, 1'b1, 8'd127, 1'b1};
    vecs[7]  = '{128'h0, 128'h0, 8'd0, 8'd0, 1'b1, 8'd128, 1'b1};
    vecs[8]  = '{128'h1, 128'h3, 8'd2, 8'd1, 1'b0, 8'd127, 1'b1};
    vecs[9]  = '{{64'h0, {64{1'b1}}}, {{64{1'b1}}, 64'h0}, 8'd129, 8'd128, 1'b0, 8'd0, 1'b0};
    vecs[10] = '{128'hF0, 128'h0F, 8'd8, 8'd8, 1'b1, 8'd120, 1'b1};

    bus.i_start = 1'b0;   bus.i_data_a = '0;   bus.i_data_b = '0;   bus.i_threshold = '0;
    bus_m.i_start = 1'b0; bus_m.i_data_a = '0; bus_m.i_data_b = '0; bus_m.i_threshold = '0;
    i_rst_n = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst/count", bus.o_count, 8'd0);
    chk("rst/done", bus.o_done, 1'b0);
    chk("rst/above", bus.o_above, 1'b0);
    chk("rst/busy", bus.o_busy, 1'b0);
    chk("rst/cmd", bus.o_shift_command, 7'h00);
    chk("rst/data", bus.o_shift_data, 128'h0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].thr, vecs[i].cnt, vecs[i].above,
            vecs[i].cnt_m, vecs[i].above_m, $sformatf("vec%0d", i));

    // Start held through all of RUN, operands disturbed mid-run: single result.
    @(negedge i_clk);
    bus.i_data_a = 128'hFF; bus.i_data_b = 128'h0; bus.i_threshold = 8'd8; bus.i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_data_a = {128{1'b1}}; bus.i_threshold = 8'd255;
    nd = 0; d1 = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_done) begin nd++; d1 = i; end
      @(negedge i_clk);
      if (i >= 7) bus.i_start = 1'b0;
    end
    chk("ignore/ndone", nd, 1);
    chk("ignore/lat", d1, 7);
    chk("ignore/count", bus.o_count, 8'd8);
    chk("ignore/above", bus.o_above, 1'b1);

    // Start held through DONE: second operation starts immediately.
    x1 = 128'hF;
    x2 = 128'h3F;
    @(negedge i_clk);
    bus.i_data_a = x1; bus.i_data_b = 128'h0; bus.i_threshold = 8'd0; bus.i_start = 1'b1;
    @(posedge i_clk);
    nd = 0; d1 = 0; d2 = 0; c1 = 8'd0; c2 = 8'd0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_done) begin
        nd++;
        if (nd == 1) begin d1 = i; c1 = bus.o_count; end
        else if (nd == 2) begin d2 = i; c2 = bus.o_count; end
      end
      @(negedge i_clk);
      if (i == 7) bus.i_data_a = x2;
      if (i == 8) bus.i_start = 1'b0;
    end
    chk("b2b/ndone", nd, 2);
    chk("b2b/first", d1, 7);
    chk("b2b/second", d2, 15);
    chk("b2b/count1", c1, 8'd4);
    chk("b2b/count2", c2, 8'd6);

    // Reset in stage 3 aborts the run.
    @(negedge i_clk);
    bus.i_data_a = {128{1'b1}}; bus.i_data_b = 128'h0; bus.i_threshold = 8'd1; bus.i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("abort/stage3", bus.o_shift_command, 7'h08);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("abort/count", bus.o_count, 8'd0);
    chk("abort/m_count", bus_m.o_count, 8'd0);
    chk("abort/busy", bus.o_busy, 1'b0);
    chk("abort/cmd", bus.o_shift_command, 7'h00);
    chk("abort/data", bus.o_shift_data, 128'h0);
    chk("abort/above", bus.o_above, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_done) nd++;
    end
    chk("abort/no_done", nd, 0);
    do_op(128'hFFFF, 128'h00FF, 8'd8, 8'd8, 1'b1, 8'd120, 1'b1, "fresh");

    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      rthr = 8'($urandom_range(0, 255));
      rc = 8'($countones(ra ^ rb));
      rcm = 8'd128 - rc;
      do_op(ra, rb, rthr, rc, (rc >= rthr), rcm, (rcm >= rthr), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pop_count_ctrl.md
Name: pop_count_ctrl

Overview:
Sequential controller that drives the correlator's one-hot 128-bit shifter, POP_COUNT_SHIFT, to compute the population count of (A XOR B), i.e. the Hamming distance between two 128-bit words. It uses a 7-stage SWAR tree, one stage per clock. The shifter stays an external combinational instance fed by this block. The block owns the working accumulator, the field masks, stage sequencing, the start/done handshake and threshold compare.

Parameters:
XOR_EN, 1, 1 = operand is i_data_a ^ i_data_b; 0 = operand is i_data_a alone (i_data_b ignored).
COUNT_MATCHES, 0, 0 = o_count reports ones in the operand; 1 = o_count reports 128 - ones (agreeing bits).

Ports:
i_clk  in  1  system clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  request; accepted only in IDLE or DONE
i_data_a  in  128  operand A, sampled on the accepting edge
i_data_b  in  128  operand B, sampled on the accepting edge
i_threshold  in  8  compare value, sampled on the accepting edge
o_shift_command  out  7  one-hot shift select to shifter
o_shift_data  out  128  data to shifter (= accumulator register)
i_shifted_data  in  128  shifter result
o_busy  out  1  high while in RUN
o_done  out  1  one-cycle pulse, result valid
o_count  out  8  result, 0..128
o_above  out  1  o_count >= captured threshold

Behaviour:
- Reset (async assert, sync release): state IDLE; acc = 0; stage = 0; o_count = 0; o_done = 0; o_above = 0; o_busy = 0; o_shift_command = 7'b0000000. Reset during RUN aborts with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE/DONE with i_start = 1 at edge E0:
  - acc <= XOR_EN ? a^b : a
  - thr <= i_threshold; stage <= 0; state <= RUN.
- Without i_start, DONE returns to IDLE. Back-to-back requests give one result per 8 cycles.
- RUN, stage k (0..6):
  - o_shift_command = 1<<k (combinational from stage); o_shift_data = acc.
  - On each edge: acc <= (acc & M_k) + (i_shifted_data & M_k), full 128-bit unsigned add. Field sums never carry across field boundaries.
  - Masks: M0 = {64{2'b01}}, M1 = {32{4'b0011}}, M2 = {16{8'h0F}}, M3 = {8{16'h00FF}}, M4 = {4{32'h0000FFFF}}, M5 = {2{64'h00000000FFFFFFFF}}, M6 = {64'h0, {64{1'b1}}}.
  - stage increments after each edge.
- Stage 6 edge (E7):
  - ones = low 8 bits of the stage-6 sum.
  - o_count <= COUNT_MATCHES ? 128 - ones : ones.
  - o_above <= (that value >= thr); o_done <= 1; state <= DONE.
- Latency: start edge E0 to o_done high in the cycle after E7, i.e. 7 cycles. o_done is high exactly one cycle. o_count and o_above hold until the next completion or reset.
- o_busy = 1 exactly in RUN (7 cycles). o_shift_command = 0 (pass-through) in IDLE and DONE.
- i_start in RUN is ignored, not queued. Operands and threshold changing during RUN have no effect.
- Count width: 128 must be representable as 8'h80 with no wrap; 128 - 0 = 128 in match mode.
- Threshold 0 gives o_above = 1 always. Threshold > 128 gives o_above = 0 always.

Test Plan:
1. a = b = random; start -> 7 cycles later o_done pulse, o_count = 0. o_shift_command sequence across RUN is 01,02,04,08,10,20,40 (hex), then 00.
2. a = all ones, b = 0; threshold 128 -> o_count = 128 (8'h80), o_above = 1. Same operands with COUNT_MATCHES = 1 -> o_count = 0, o_above = 0.
3. a = {64{2'b10}}, b = 0 -> o_count = 64. a = only bit 127 set, b = 0 -> o_count = 1. 1000 random pairs checked against a reference popcount.
4. Start re-asserted on every RUN cycle -> ignored, single done. Start held through DONE -> second operation begins; done pulses 8 cycles apart.
5. i_rst_n low during stage 3 -> all outputs at reset values immediately. After release, start -> correct fresh result, no spurious done.
6. Threshold boundaries: count 64 with thr 64 -> o_above = 1; thr 65 -> 0; thr 0 -> 1; thr 200 -> 0.
